key_unlock_gate: RTL and testbench

KEY_UNLOCK_GATE -- requirements
Module: key_unlock_gate

---
 rtl/key_unlock_if.sv | 24 ++
 rtl/key_unlock_gate.sv | 72 +++++++
 tb/tb_key_unlock_gate.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/key_unlock_if.sv
// key_unlock_if: key entry, relock, operand and status signals of key_unlock_gate.
interface key_unlock_if;
    logic       start;
    logic       key_vld;
    logic       key_bit;
    logic       relock;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] sum_out;
    logic       unlocked;
    logic       lockout;
    logic       busy;
    logic [1:0] fail_cnt;

    modport master (
        output start, key_vld, key_bit, relock, op_a, op_b,
        input  sum_out, unlocked, lockout, busy, fail_cnt
    );

    modport slave (
        input  start, key_vld, key_bit, relock, op_a, op_b,
        output sum_out, unlocked, lockout, busy, fail_cnt
    );
endinterface

// File: rtl/key_unlock_gate.sv
// key_unlock_gate: serial-key unlock FSM gating an 8-bit adder; scrambled XOR output while locked,
// with saturating failure count and terminal lockout.
module key_unlock_gate #(
    parameter logic [15:0] KEY      = 16'hA5C3,
    parameter logic [1:0]  MAX_FAIL = 2'd3,
    parameter logic [7:0]  SCRAMBLE = 8'h5A
) (
    input logic          clk,
    input logic          rst_n,
    key_unlock_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, UNLOCKED, LOCKOUT} state_t;

    state_t      state;
    logic [15:0] shreg;
    logic [4:0]  cnt;
    logic [1:0]  fail_q;
    logic [7:0]  sum_q;
    logic [1:0]  fail_nxt;

    // Saturating increment: the count never wraps back to zero.
    assign fail_nxt = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            fail_q <= '0;
            sum_q  <= '0;
        end else begin
            sum_q <= (state == UNLOCKED) ? bus.op_a + bus.op_b : bus.op_a ^ bus.op_b ^ SCRAMBLE;
            case (state)
                IDLE, UNLOCKED: begin
                    if (bus.start) begin
                        state <= SHIFT;
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (state == UNLOCKED && bus.relock) begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bus.start) begin
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (bus.key_vld) begin
                        shreg <= {shreg[14:0], bus.key_bit};
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd15) state <= CHECK;
                    end
                end
                CHECK: begin
                    if (shreg == KEY) begin
                        state  <= UNLOCKED;
                        fail_q <= '0;
                    end else begin
                        fail_q <= fail_nxt;
                        state  <= (fail_nxt == MAX_FAIL) ? LOCKOUT : IDLE;
                    end
                end
                default: state <= LOCKOUT;
            endcase
        end
    end

    assign bus.sum_out  = sum_q;
    assign bus.fail_cnt = fail_q;
    assign bus.unlocked = (state == UNLOCKED);
    assign bus.lockout  = (state == LOCKOUT);
    assign bus.busy     = (state == SHIFT) || (state == CHECK);
endmodule

// File: tb/tb_key_unlock_gate.sv
// tb_key_unlock_gate: directed vectors with hand-computed expectations for key_unlock_gate.
module tb_key_unlock_gate;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   busy_cycles;

    key_unlock_if bus ();

    key_unlock_gate dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.busy === 1'b1) busy_cycles++;
    endtask

    task automatic check_outs(input string tag, input logic u, input logic l, input logic b,
                              input logic [1:0] f);
        check({tag, ".unlocked"}, {15'd0, bus.unlocked}, {15'd0, u});
        check({tag, ".lockout"}, {15'd0, bus.lockout}, {15'd0, l});
        check({tag, ".busy"}, {15'd0, bus.busy}, {15'd0, b});
        check({tag, ".fail_cnt"}, {14'd0, bus.fail_cnt}, {14'd0, f});
    endtask

    // Start pulse, then 16 bits MSB first; key_vld drops for gap_len cycles after gap_after bits.
    task automatic send_key(input logic [15:0] k, input int gap_after, input int gap_len);
        busy_cycles = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 16; n++) begin
            bus.key_vld = 1'b1;
            bus.key_bit = k[15-n];
            tick();
            bus.key_vld = 1'b0;
            if (n + 1 == gap_after)
                for (int g = 0; g < gap_len; g++) tick();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key_vld = 1'b0;
        bus.key_bit = 1'b0;
        bus.relock = 1'b0;
        bus.op_a = 8'h00;
        bus.op_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        check("reset.sum", {8'd0, bus.sum_out}, 16'h0000);

        // Locked operation
        #2 rst_n = 1'b1;
        bus.op_a = 8'h12;
        bus.op_b = 8'h34;
        tick();
        check("locked.sum", {8'd0, bus.sum_out}, 16'h007C);

        // Correct key, continuous
        send_key(16'hA5C3, 0, 0);
        check("key.busy_cycles", busy_cycles[15:0], 16'd17);
        bus.op_a = 8'hF0;
        bus.op_b = 8'h20;
        tick();
        check_outs("key", 1'b1, 1'b0, 1'b0, 2'd0);
        check("key.sum_check_edge", {8'd0, bus.sum_out}, 16'h008A);
        tick();
        check("key.sum_add", {8'd0, bus.sum_out}, 16'h0010);

        // Relock
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
        check_outs("relock", 1'b0, 1'b0, 1'b0, 2'd0);
        check("relock.sum_last_add", {8'd0, bus.sum_out}, 16'h0010);
        tick();
        check("relock.sum_scr", {8'd0, bus.sum_out}, 16'h008A);

        // Relock ignored in IDLE
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
        check_outs("idle_relock", 1'b0, 1'b0, 1'b0, 2'd0);

        // Gapped entry
        send_key(16'hA5C3, 7, 3);
        check("gap.busy_cycles", busy_cycles[15:0], 16'd20);
        tick();
        check_outs("gap", 1'b1, 1'b0, 1'b0, 2'd0);

        // Start beats relock in UNLOCKED; restart after 9 bits, then full key
        bus.start = 1'b1;
        bus.relock = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.relock = 1'b0;
        check_outs("start_relock", 1'b0, 1'b0, 1'b1, 2'd0);
        for (int n = 0; n < 9; n++) begin
            bus.key_vld = 1'b1;
            bus.key_bit = 1'b1;
            tick();
        end
        bus.key_vld = 1'b0;
        check_outs("partial", 1'b0, 1'b0, 1'b1, 2'd0);
        send_key(16'hA5C3, 0, 0);
        tick();
        check_outs("restart", 1'b1, 1'b0, 1'b0, 2'd0);

        // Three wrong keys -> lockout
        for (int t = 1; t <= 3; t++) begin
            send_key(16'h0000, 0, 0);
            tick();
            check_outs($sformatf("wrong%0d", t), 1'b0, t == 3, 1'b0, t[1:0]);
        end

        // Lockout ignores correct key and relock
        send_key(16'hA5C3, 0, 0);
        check("lockout.busy_cycles", busy_cycles[15:0], 16'd0);
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
        check_outs("lockout_hold", 1'b0, 1'b1, 1'b0, 2'd3);
        bus.op_a = 8'hF0;
        bus.op_b = 8'h20;
        tick();
        check("lockout.sum", {8'd0, bus.sum_out}, 16'h008A);

        // Reset clears lockout
        #2 rst_n = 1'b0;
        #1;
        check_outs("lockout_rst", 1'b0, 1'b0, 1'b0, 2'd0);
        #2 rst_n = 1'b1;

        // Async reset mid-SHIFT, then partial bits must be gone
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            bus.key_vld = 1'b1;
            bus.key_bit = 1'b1;
            tick();
        end
        bus.key_vld = 1'b0;
        check_outs("pre_async", 1'b0, 1'b0, 1'b1, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
        check("async_rst.sum", {8'd0, bus.sum_out}, 16'h0000);
        #2 rst_n = 1'b1;
        send_key(16'hA5C3, 0, 0);
        tick();
        check_outs("post_rst_key", 1'b1, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
